fifo_rd_packer: RTL and testbench

Read-side consumer for the asynchronous FIFO. It pops DSIZE-bit entries from the FIFO read port and assembles WORDS consecutive entries into one wide word. The word is presented downstream on a valid/ready handshake. It runs entirely in the FIFO read clock domain and connects directly to the FIFO's rdata/rinc/rempty pins.

---
 rtl/fifo_rd_packer.sv | 112 +++++++++++
 tb/tb_fifo_rd_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Packs WORDS consecutive FIFO read entries into one wide valid/ready word.
// Optional idle auto-flush: define FIFO_RD_PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int DSIZE   = 8,
    parameter int WORDS   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic                   rempty,
    input  logic [DSIZE-1:0]       rdata,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*WORDS-1:0] out_data,
    output logic [WORDS-1:0]       out_keep,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int OSIZE = DSIZE * WORDS;
    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [OSIZE-1:0] data_q, data_n;
    logic [WORDS-1:0] keep_q, keep_n;
    logic             timeout_hit;
    logic             flush_cond;
    logic             pop;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle, idle_n;

    assign timeout_hit = (idle == TW'(TIMEOUT));

    // Counts only while a partial word waits on an empty FIFO.
    always_comb begin
        idle_n = '0;
        if (state == FILL && cnt != '0 && rempty && !flush_cond)
            idle_n = idle + 1'b1;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) idle <= '0;
        else         idle <= idle_n;
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign flush_cond = (state == FILL) && (cnt != '0)
                      && (flush || timeout_hit);
    assign pop        = (state == FILL) && !rempty && !flush_cond;
    // Reset gates only the pin so rrst_n stays out of the flop data paths.
    assign rinc       = pop && rrst_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = data_q;
        keep_n  = keep_q;
        unique case (state)
            FILL: begin
                if (flush_cond) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (pop) begin
                    data_n[cnt*DSIZE +: DSIZE] = rdata;
                    keep_n[cnt]                = 1'b1;
                    if (cnt == LAST) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = FILL;
                    data_n  = '0;
                    keep_n  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state  <= FILL;
            cnt    <= '0;
            data_q <= '0;
            keep_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            keep_q <= keep_n;
        end
    end

    assign out_valid = (state == HOLD);
    assign out_data  = data_q;
    assign out_keep  = keep_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer with a behavioural show-ahead FIFO.
// Expected words are queued by the stimulus; a monitor checks each handshake.
module tb_fifo_rd_packer;
    localparam int DSIZE = 8;
    localparam int WORDS = 4;
    localparam int OSIZE = 32;

    typedef struct {
        logic [OSIZE-1:0] data;
        logic [WORDS-1:0] keep;
    } exp_t;

    logic             rclk = 1'b0;
    logic             rrst_n = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic             rinc;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic [OSIZE-1:0] out_data;
    logic [WORDS-1:0] out_keep;
    logic             out_valid;

    logic [DSIZE-1:0] mem [256];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic [7:0]       rd_idx;

    exp_t sb[$];
    int   vectors = 0;
    int   errors = 0;
    int   rinc_cnt = 0;
    int   valid_rises = 0;
    logic pop_now = 1'b0;
    logic prev_valid = 1'b0;

    assign rd_idx = rd_ptr[7:0];
    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_idx];

    fifo_rd_packer #(.DSIZE(DSIZE), .WORDS(WORDS), .TIMEOUT(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .flush(flush), .out_data(out_data),
        .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (pop_now) rd_ptr <= rd_ptr + 1;
    end

    // Monitor: inputs change just after posedge, so mid-cycle values are stable.
    always @(negedge rclk) begin
        exp_t e;
        pop_now = rinc;
        if (rinc) begin
            rinc_cnt++;
            vectors++;
            if (rempty) begin
                errors++;
                $display("FAIL pop_on_empty: rinc=1 rempty=1 required rinc=0");
            end
        end
        if (out_valid && !prev_valid) valid_rises++;
        prev_valid = out_valid;
        if (out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: data=%h keep=%b", out_data, out_keep);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_keep !== e.keep) begin
                    errors++;
                    $display("FAIL word: data=%h keep=%b required data=%h keep=%b",
                             out_data, out_keep, e.data, e.keep);
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        sb.push_back('{d, k});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget && rd_ptr != wr_ptr; i++) step(1);
        check("fifo_drained", 64'(rd_ptr == wr_ptr), 64'd1);
    endtask

    task automatic wait_sb_empty(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
        check("words_delivered", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !out_valid; i++) @(negedge rclk);
        check("valid_seen", 64'(out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0;
        int v0;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset state, with an entry already waiting in the FIFO
        out_ready = 1'b1;
        push(8'h11);
        @(negedge rclk);
        check("reset_rinc", 64'(rinc), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_keep", 64'(out_keep), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        r0 = rinc_cnt;
        v0 = valid_rises;
        step(1);
        rrst_n = 1'b1;

        // Steady stream
        push(8'h22); push(8'h33); push(8'h44);
        expect_word(32'h44332211, 4'b1111);
        wait_sb_empty(40);
        step(2);
        check("steady_rinc_pulses", 64'(rinc_cnt - r0), 64'd4);
        check("steady_valid_pulses", 64'(valid_rises - v0), 64'd1);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        expect_word(32'h04030201, 4'b1111);
        expect_word(32'h08070605, 4'b1111);
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            check("bp_data_stable", 64'(out_data), 64'h04030201);
            check("bp_no_pop", 64'(rinc), 64'd0);
        end
        @(posedge rclk);
        #1;
        out_ready = 1'b1;
        wait_sb_empty(40);

        // Partial flush on empty FIFO
        push(8'hAA); push(8'hBB);
        wait_drained(10);
        flush = 1'b1;
        expect_word(32'h0000BBAA, 4'b0011);
        step(1);
        flush = 1'b0;
        wait_sb_empty(20);

        // Flush colliding with a pop
        push(8'h10);
        wait_drained(10);
        push(8'h20);
        flush = 1'b1;
        @(negedge rclk);
        check("collide_no_pop", 64'(rinc), 64'd0);
        @(posedge rclk);
        #1;
        flush = 1'b0;
        expect_word(32'h00000010, 4'b0001);
        push(8'h30); push(8'h40); push(8'h50);
        expect_word(32'h50403020, 4'b1111);
        wait_sb_empty(40);

        // Flush with cnt=0 is ignored
        step(2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge rclk);
        check("flush_idle_ignored", 64'(out_valid), 64'd0);

        // Flush in HOLD is ignored
        out_ready = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        expect_word(32'hC4C3C2C1, 4'b1111);
        wait_valid(20);
        @(posedge rclk);
        #1;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge rclk);
        check("hold_flush_keep", 64'(out_keep), 64'hF);
        check("hold_flush_data", 64'(out_data), 64'hC4C3C2C1);
        @(posedge rclk);
        #1;
        out_ready = 1'b1;
        wait_sb_empty(20);

        // Timeout
        push(8'h5A);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        expect_word(32'h0000005A, 4'b0001);
        @(negedge rclk);
        check("timeout_pop", 64'(rinc), 64'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge rclk);
            n++;
        end
        check("timeout_latency", 64'(n), 64'd18);
        check("timeout_keep", 64'(out_keep), 64'b0001);
        wait_sb_empty(10);
`else
        n = 0;
        repeat (100) @(negedge rclk);
        check("no_timeout_valid", 64'(out_valid), 64'd0);
        check("no_timeout_drained", 64'(rd_ptr == wr_ptr), 64'd1);
        @(posedge rclk);
        #1;
        flush = 1'b1;
        expect_word(32'h0000005A, 4'b0001);
        step(1);
        flush = 1'b0;
        wait_sb_empty(10);
`endif

        // Reset mid-word
        push(8'h61); push(8'h62);
        wait_drained(10);
        rrst_n = 1'b0;
        push(8'h71);
        @(negedge rclk);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_keep", 64'(out_keep), 64'd0);
        check("midrst_rinc", 64'(rinc), 64'd0);
        step(1);
        rrst_n = 1'b1;
        push(8'h72); push(8'h73); push(8'h74);
        expect_word(32'h74737271, 4'b1111);
        wait_sb_empty(40);

        step(5);
        check("no_leftover", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
